spi_mosi_tx: RTL

SPI master transmitter: takes bytes with a command/data flag from an upstream source over a valid/ready handshake and shifts them out MSB-first on SPI_CLK/SPI_DATA. It drives DC_out and an active-low frame select, SPI_CS. It sits in front of the team's SPI byte receivers and LED-panel command ports, and is the sending end of the same link. Mode 0: data changes while SPI_CLK is low, and the receiver samples on the rising edge.

---
 rtl/spi_mosi_tx.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/spi_mosi_tx.sv
// Mode-0 SPI master transmitter: bytes with a command/data flag arrive on a valid/ready
// handshake and are shifted out MSB-first, with SPI_CS held low across a multi-byte frame.
module spi_mosi_tx #(
   parameter int DIV = 4,
   parameter int GAP = 8
) (
   input  logic       SCLK,
   input  logic       Rst,
   input  logic [7:0] tx_data,
   input  logic       tx_dc,
   input  logic       tx_last,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic       SPI_CLK,
   output logic       SPI_DATA,
   output logic       DC_out,
   output logic       SPI_CS,
   output logic       busy
);

   typedef enum logic [2:0] {
      S_IDLE, S_SETUP, S_HIGH, S_LOW, S_TAIL, S_GAP, S_WAIT, S_HOLD
   } state_e;

   localparam logic [7:0] DIV_LAST = 8'(DIV - 1);
   localparam logic [7:0] GAP_LAST = 8'(GAP - 1);

   state_e      state_q, state_d;
   logic [7:0]  div_q, div_d;
   logic [2:0]  bit_q, bit_d;
   logic [6:0]  shift_q, shift_d;
   logic        last_q, last_d;
   logic        clk_q, clk_d;
   logic        data_q, data_d;
   logic        dc_q, dc_d;
   logic        cs_q, cs_d;
   logic        ready_q, ready_d;
   logic        busy_q, busy_d;

   logic        div_done;
   logic        accept;

   assign div_done = (div_q == DIV_LAST);
   assign accept   = tx_valid & ready_q;

   // NOTE: every output of this block below is a default copy of its register, so no
   // path through the case leaves a signal unassigned and no latch is inferred.
   always_comb begin
      state_d = state_q;
      div_d   = div_q + 8'd1;
      bit_d   = bit_q;
      shift_d = shift_q;
      last_d  = last_q;
      clk_d   = clk_q;
      data_d  = data_q;
      dc_d    = dc_q;
      cs_d    = cs_q;
      ready_d = ready_q;

      case (state_q)
         S_IDLE: begin
            cs_d    = 1'b1;
            ready_d = 1'b1;
            div_d   = '0;
         end
         S_WAIT: begin
            ready_d = 1'b1;
            div_d   = '0;
         end
         S_SETUP: begin
            if (div_done) begin
               clk_d   = 1'b1;
               bit_d   = bit_q + 3'd1;
               div_d   = '0;
               state_d = S_HIGH;
            end
         end
         S_HIGH: begin
            if (div_done) begin
               div_d = '0;
               // The 3-bit edge count wraps to zero on the eighth rising edge.
               if (bit_q != 3'd0) begin
                  clk_d   = 1'b0;
                  shift_d = {shift_q[5:0], 1'b0};
                  data_d  = shift_q[6];
                  state_d = S_LOW;
               end else begin
                  state_d = S_TAIL;
               end
            end
         end
         S_TAIL: begin
            // Last bit stays high one extra half-period so a byte spans 17*DIV cycles.
            if (div_done) begin
               clk_d   = 1'b0;
               div_d   = '0;
               state_d = last_q ? S_HOLD : S_GAP;
            end
         end
         S_LOW: begin
            if (div_done) begin
               clk_d   = 1'b1;
               bit_d   = bit_q + 3'd1;
               div_d   = '0;
               state_d = S_HIGH;
            end
         end
         S_GAP: begin
            if (div_q == GAP_LAST) begin
               ready_d = 1'b1;
               div_d   = '0;
               state_d = S_WAIT;
            end
         end
         S_HOLD: begin
            if (div_done) begin
               cs_d    = 1'b1;
               ready_d = 1'b1;
               div_d   = '0;
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Accepting from WAIT is identical to IDLE; SPI_CS is simply already low.
      if (accept && (state_q == S_IDLE || state_q == S_WAIT)) begin
         shift_d = tx_data[6:0];
         data_d  = tx_data[7];
         dc_d    = tx_dc;
         last_d  = tx_last;
         cs_d    = 1'b0;
         ready_d = 1'b0;
         bit_d   = '0;
         div_d   = '0;
         state_d = S_SETUP;
      end

      busy_d = (state_d != S_IDLE);
   end

   // NOTE: state registers use non-blocking assignments so every register samples the
   // pre-edge value of the others, independent of statement order.
   always_ff @(posedge SCLK) begin
      if (Rst) begin
         state_q <= S_IDLE;
         div_q   <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         last_q  <= 1'b0;
         clk_q   <= 1'b0;
         data_q  <= 1'b0;
         dc_q    <= 1'b0;
         cs_q    <= 1'b1;
         ready_q <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         div_q   <= div_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         last_q  <= last_d;
         clk_q   <= clk_d;
         data_q  <= data_d;
         dc_q    <= dc_d;
         cs_q    <= cs_d;
         ready_q <= ready_d;
         busy_q  <= busy_d;
      end
   end

   assign tx_ready = ready_q;
   assign SPI_CLK  = clk_q;
   assign SPI_DATA = data_q;
   assign DC_out   = dc_q;
   assign SPI_CS   = cs_q;
   assign busy     = busy_q;

endmodule
